// File: rtl/q2_pkg.sv
// q2_pkg: shared shifter state type and X-source/shift-direction encodings.
package q2_pkg;
  typedef enum logic {IDLE, SHIFT} shift_state_t;
  localparam logic [3:0] XIN_ZERO  = 4'b1000;
  localparam logic [3:0] XIN_SHIFT = 4'b0100;
  localparam logic [3:0] XIN_P     = 4'b0010;
  localparam logic [3:0] XIN_DBUS  = 4'b0001;
  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;
endpackage

// File: rtl/q2_xshift.sv
// q2_xshift: X register with single-step loads and a multi-cycle serial shifter.
module q2_xshift
  import q2_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wrx,
  input  logic [3:0]       i_xin,
  input  logic             i_shift_in,
  input  logic             i_shift_dir,
  input  logic             i_shift_start,
  input  logic [SHW-1:0]   i_shift_amt,
  input  logic [WIDTH-1:0] i_p,
  input  logic [WIDTH-1:0] i_dbus,
  output logic [WIDTH-1:0] o_x,
  output logic             o_busy,
  output logic             o_done
);
  localparam logic [SHW-1:0] MAX_AMT = SHW'(WIDTH);
  shift_state_t     r_state, w_state_nx;
  logic [WIDTH-1:0] r_x, w_x_nx, w_x_sh;
  logic [SHW-1:0]   r_cnt, w_cnt_nx, w_amt;
  logic             r_done, w_done_nx;
  assign w_x_sh = (i_shift_dir == SHIFT_RIGHT) ? {i_shift_in, r_x[WIDTH-1:1]} : {r_x[WIDTH-2:0], i_shift_in};
  assign w_amt  = (i_shift_amt > MAX_AMT) ? MAX_AMT : i_shift_amt;
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_cnt_nx   = r_cnt;
    w_done_nx  = 1'b0;
    if (r_state == SHIFT) begin
      w_x_nx   = w_x_sh;
      w_cnt_nx = r_cnt - SHW'(1);
      if (r_cnt == SHW'(1)) begin
        w_state_nx = IDLE;
        w_done_nx  = 1'b1;
      end
    end else begin
      if (i_wrx)
        w_x_nx = (i_xin == XIN_ZERO)  ? '0 :
                 (i_xin == XIN_SHIFT) ? w_x_sh :
                 (i_xin == XIN_P)     ? i_p :
                 (i_xin == XIN_DBUS)  ? i_dbus : r_x;
      if (i_shift_start) begin
        w_done_nx  = (w_amt == '0);
        w_state_nx = (w_amt == '0) ? IDLE : SHIFT;
        w_cnt_nx   = w_amt;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_x     <= w_x_nx;
      r_cnt   <= w_cnt_nx;
      r_done  <= w_done_nx;
    end
  end
  assign o_x    = r_x;
  assign o_busy = (r_state == SHIFT);
  assign o_done = r_done;
endmodule

// File: rtl/q2_slice_word.sv
// q2_slice_word: word-wide Q2 register slice with A/X/P/S registers and bus drive muxing.
module q2_slice_word
  import q2_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             dep,
  input  logic [WIDTH-1:0] dbus_in,
  output logic [WIDTH-1:0] dbus_out,
  output logic             dbus_oe,
  output logic [WIDTH-1:0] abus_out,
  output logic             abus_oe,
  input  logic             wra,
  input  logic             rda,
  input  logic [WIDTH-1:0] ain,
  input  logic             incp,
  input  logic             wrp,
  input  logic             rdp,
  input  logic             wrx,
  input  logic             rdx,
  input  logic [3:0]       xin,
  input  logic             shift_in,
  input  logic             shift_dir,
  input  logic             shift_start,
  input  logic [SHW-1:0]   shift_amt,
  input  logic             wrs,
  input  logic             sin,
  output logic [WIDTH-1:0] aout,
  output logic [WIDTH-1:0] xout,
  output logic [WIDTH-1:0] pout,
  output logic             sout,
  output logic             p_wrap,
  output logic             busy,
  output logic             done,
  output logic             bus_conflict
);
  logic [WIDTH-1:0] r_a, r_p, w_x;
  logic             r_s, r_p_wrap;
  q2_xshift #(.WIDTH(WIDTH), .SHW(SHW)) u_xshift (
    .clk(clk), .rst(rst), .i_wrx(wrx), .i_xin(xin), .i_shift_in(shift_in),
    .i_shift_dir(shift_dir), .i_shift_start(shift_start), .i_shift_amt(shift_amt),
    .i_p(r_p), .i_dbus(dbus_in), .o_x(w_x), .o_busy(busy), .o_done(done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_p      <= sw;
      r_s      <= 1'b0;
      r_p_wrap <= 1'b0;
    end else begin
      if (wra) r_a <= ain;
      if (wrs) r_s <= sin;
      r_p      <= wrp ? w_x : incp ? r_p + WIDTH'(1) : r_p;
      r_p_wrap <= ~wrp & incp & (&r_p);
    end
  end
  assign dbus_out     = dep ? sw : rda ? r_a : '0;
  assign dbus_oe      = dep | rda;
  assign abus_out     = rdp ? r_p : rdx ? w_x : '0;
  assign abus_oe      = rdp | rdx;
  assign bus_conflict = (dep & rda) | (rdp & rdx);
  assign aout   = r_a;
  assign xout   = w_x;
  assign pout   = r_p;
  assign sout   = r_s;
  assign p_wrap = r_p_wrap;
endmodule

// File: tb/tb_q2_slice_word.sv
// tb_q2_slice_word: scoreboard bench for q2_slice_word at WIDTH=8.
module tb_q2_slice_word;
  import q2_pkg::*;
  logic clk = 0, rst = 0;
  logic [7:0] sw = 0, dbus_in = 0, ain = 0;
  logic dep = 0, wra = 0, rda = 0, incp = 0, wrp = 0, rdp = 0, wrx = 0, rdx = 0;
  logic [3:0] xin = 0, shift_amt = 0;
  logic shift_in = 0, shift_dir = 0, shift_start = 0, wrs = 0, sin = 0;
  logic [7:0] dbus_out, abus_out, aout, xout, pout;
  logic dbus_oe, abus_oe, sout, p_wrap, busy, done, bus_conflict;
  int checks = 0, errors = 0;
  string q_tag[$];
  logic [31:0] q_exp[$];
  int nb;
  bit got;
  int ndone;
  q2_slice_word #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sw(sw), .dep(dep), .dbus_in(dbus_in), .dbus_out(dbus_out),
    .dbus_oe(dbus_oe), .abus_out(abus_out), .abus_oe(abus_oe), .wra(wra), .rda(rda),
    .ain(ain), .incp(incp), .wrp(wrp), .rdp(rdp), .wrx(wrx), .rdx(rdx), .xin(xin),
    .shift_in(shift_in), .shift_dir(shift_dir), .shift_start(shift_start),
    .shift_amt(shift_amt), .wrs(wrs), .sin(sin), .aout(aout), .xout(xout), .pout(pout),
    .sout(sout), .p_wrap(p_wrap), .busy(busy), .done(done), .bus_conflict(bus_conflict)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_exp.push_back(exp);
  endtask
  task automatic pop_chk(input logic [31:0] obs);
    if (q_exp.size() == 0) chk("sb_empty", q_exp.size(), 1);
    else chk(q_tag.pop_front(), obs, q_exp.pop_front());
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic load_x(input logic [7:0] v);
    wrx = 1; xin = XIN_DBUS; dbus_in = v;
    tick();
    wrx = 0; xin = 0;
  endtask
  task automatic run_shift(input logic [3:0] amt, input logic dir, input logic fill, input bit hold_wrx);
    shift_amt = amt; shift_dir = dir; shift_in = fill; shift_start = 1;
    tick();
    shift_start = 0;
    if (hold_wrx) begin wrx = 1; xin = XIN_DBUS; dbus_in = 8'h55; end
    nb = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (busy) nb++;
      if (done) got = 1; else tick();
    end
    wrx = 0; xin = 0;
  endtask
  initial begin
    sw = 8'hA5; rst = 1;
    tick();
    rst = 0;
    chk("rst_p", pout, 8'hA5);
    chk("rst_a", aout, 0);
    chk("rst_x", xout, 0);
    chk("rst_s", sout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", p_wrap, 0);
    wra = 1; ain = 8'h5A; wrs = 1; sin = 1;
    tick();
    wra = 0; wrs = 0;
    chk("wra", aout, 8'h5A);
    chk("wrs", sout, 1);
    push("x_ff", 8'hFF); load_x(8'hFF); pop_chk(xout);
    wrp = 1; tick(); wrp = 0;
    chk("wrp_ff", pout, 8'hFF);
    chk("wrp_nowrap", p_wrap, 0);
    incp = 1; tick(); incp = 0;
    chk("inc_wrap_p", pout, 8'h00);
    chk("wrap_hi", p_wrap, 1);
    tick();
    chk("wrap_lo", p_wrap, 0);
    incp = 1; tick(); incp = 0;
    chk("inc_p", pout, 8'h01);
    push("x_dbus", 8'h3C); load_x(8'h3C); pop_chk(xout);
    wrx = 1; xin = 4'b0011; dbus_in = 8'h00;
    push("x_hold", 8'h3C); tick(); wrx = 0; pop_chk(xout);
    wrp = 1; incp = 1; tick(); wrp = 0; incp = 0;
    chk("wrp_wins", pout, 8'h3C);
    wrx = 1; xin = XIN_SHIFT; shift_dir = SHIFT_LEFT; shift_in = 1;
    push("x_step", 8'h79); tick(); pop_chk(xout);
    xin = XIN_P; push("x_from_p", 8'h3C); tick(); pop_chk(xout);
    xin = XIN_ZERO; push("x_zero", 8'h00); tick(); wrx = 0; pop_chk(xout);
    load_x(8'h81);
    push("shl3", 8'h0F);
    run_shift(4'd3, SHIFT_LEFT, 1'b1, 1'b1);
    chk("shl3_done", got, 1);
    pop_chk(xout);
    chk("shl3_busy", nb, 3);
    tick();
    chk("shl3_done_lo", done, 0);
    chk("shl3_wrx_ign", xout, 8'h0F);
    push("amt0", 8'h0F);
    run_shift(4'd0, SHIFT_LEFT, 1'b1, 1'b0);
    chk("amt0_done", got, 1);
    pop_chk(xout);
    chk("amt0_busy", nb, 0);
    tick();
    chk("amt0_done_lo", done, 0);
    load_x(8'hFF);
    push("shr12", 8'h00);
    run_shift(4'd12, SHIFT_RIGHT, 1'b0, 1'b0);
    chk("shr12_done", got, 1);
    pop_chk(xout);
    chk("shr12_busy", nb, 8);
    load_x(8'hF0);
    shift_amt = 4'd5; shift_dir = SHIFT_LEFT; shift_in = 1; shift_start = 1;
    tick();
    shift_start = 0;
    chk("mid_busy1", busy, 1);
    tick();
    chk("mid_busy2", busy, 1);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", xout, 0);
    chk("mid_rst_p", pout, 8'hA5);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("mid_rst_nodone", ndone, 0);
    push("post_rst_shl2", 8'h03);
    run_shift(4'd2, SHIFT_LEFT, 1'b1, 1'b0);
    chk("post_rst_done", got, 1);
    pop_chk(xout);
    chk("post_rst_busy", nb, 2);
    sw = 8'h11; wra = 1; ain = 8'h22; tick(); wra = 0;
    dep = 1; rda = 1; #1;
    chk("dep_out", dbus_out, 8'h11);
    chk("dep_oe", dbus_oe, 1);
    chk("dep_conf", bus_conflict, 1);
    dep = 0; #1;
    chk("rda_out", dbus_out, 8'h22);
    chk("rda_conf", bus_conflict, 0);
    rda = 0; rdp = 1; #1;
    chk("rdp_out", abus_out, 8'hA5);
    chk("rdp_oe", abus_oe, 1);
    chk("rdp_conf", bus_conflict, 0);
    rdx = 1; #1;
    chk("rdpx_out", abus_out, 8'hA5);
    chk("rdpx_conf", bus_conflict, 1);
    rdp = 0; #1;
    chk("rdx_out", abus_out, 8'h03);
    rdx = 0; #1;
    chk("idle_dbus", {dbus_oe, dbus_out}, 0);
    chk("idle_abus", {abus_oe, abus_out}, 0);
    tick();
    chk("conf_nostate_p", pout, 8'hA5);
    chk("sb_drained", q_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/q2_slice_word.md
Name: q2_slice_word

Overview:
- Parametrised, fully synchronous successor to the 1-bit Q2 register slice.
- Holds WIDTH-bit A (accumulator), X (index/shift), P (program counter) and a 1-bit S (status).
- Tristate dbus/abus become explicit data-out/enable pairs, merged at top level.
- New behaviour: carry-chained P increment with wrap pulse, multi-cycle X shifter with busy/done handshake, bus-conflict detection.

Parameters:
- WIDTH, 8, datapath width in bits (>=2).
- SHW, $clog2(WIDTH)+1, width of shift_amt. Derived; do not override.

Ports:
- clk in 1: single system clock, all state updates on its rising edge.
- rst in 1: synchronous active-high reset.
- sw in WIDTH: front-panel switches.
- dep in 1: drive sw onto dbus.
- dbus_in in WIDTH: resolved data bus value.
- dbus_out out WIDTH: this block's dbus drive value.
- dbus_oe out 1: dbus drive enable.
- abus_out out WIDTH: this block's abus drive value.
- abus_oe out 1: abus drive enable.
- wra in 1: load A from ain.
- rda in 1: drive A onto dbus.
- ain in WIDTH: A load value.
- incp in 1: increment P.
- wrp in 1: load P from X.
- rdp in 1: drive P onto abus.
- wrx in 1: load X.
- rdx in 1: drive X onto abus.
- xin in 4: one-hot X source {zero, shift, p, dbus}, MSB first.
- shift_in in 1: serial bit entering X on a shift.
- shift_dir in 1: 0 = left (LSB fill), 1 = right (MSB fill).
- shift_start in 1: begin multi-bit shift.
- shift_amt in SHW: shift count.
- wrs in 1: load S from sin.
- sin in 1: S load value.
- aout, xout, pout out WIDTH: register taps.
- sout out 1: S tap.
- p_wrap out 1: one-cycle pulse on P wrap.
- busy out 1: shifter active.
- done out 1: one-cycle pulse at shift completion.
- bus_conflict out 1: two sources requested the same bus this cycle.

Behaviour:
- Reset (rst=1 at clk edge): A=0, X=0, P=sw, S=0, busy=0, done=0, p_wrap=0, shifter IDLE. rst overrides all other inputs that cycle.
- A: wra -> A<=ain next edge.
- S: wrs -> S<=sin.
- P priority: wrp > incp.
  - wrp -> P<=X, using X value before this edge.
  - incp -> P<=P+1 mod 2^WIDTH.
  - p_wrap=1 for one cycle after an incp that takes P from all-ones to 0. Never asserted on wrp.
- X single-step load (wrx while busy=0):
  - xin=1000 -> 0.
  - xin=0100 -> one shift by shift_dir with shift_in.
  - xin=0010 -> P (pre-edge value).
  - xin=0001 -> dbus_in.
  - Any non-one-hot xin: X holds.
- Shifter FSM (IDLE, SHIFT):
  - IDLE + shift_start:
    - amt = min(shift_amt, WIDTH).
    - amt=0: stay IDLE, done pulses next cycle, X unchanged.
    - Otherwise: cnt<=amt, busy<=1, go SHIFT.
  - SHIFT: each cycle X shifts 1 bit per shift_dir, filling with the current shift_in, and cnt decrements.
  - When cnt==1 at an edge: last shift occurs, busy<=0, done<=1 for one cycle, go IDLE.
  - Latency: amt cycles of busy. done is high in the cycle after the last shift.
  - While busy: wrx and shift_start are ignored. wrp and rdx see the in-progress X.
  - rst mid-shift: IDLE, X=0, no done pulse.
- Bus drive (combinational from registered state):
  - dbus: dep has priority over rda. dbus_oe = dep|rda.
  - abus: rdp has priority over rdx. abus_oe = rdp|rdx.
  - When not enabled, the bus output is 0.
  - bus_conflict = (dep&rda)|(rdp&rdx). Combinational; no state change.
- No internal arithmetic beyond P+1 and the shift count. Widths are never extended; overflow wraps.

Decomposition:
- q2_pkg:
  - shifter state enum (IDLE, SHIFT).
  - XIN_ZERO/XIN_SHIFT/XIN_P/XIN_DBUS one-hot constants.
  - SHIFT_LEFT/SHIFT_RIGHT constants.
- Natural sub-module: q2_xshift, holding the X register, shifter FSM, count, busy/done. The top instantiates it and keeps A/P/S and the bus muxing.

Test Plan (WIDTH=8):
1. Reset value and wrap:
   - Stimulus: sw=0xA5, rst pulse.
   - Required: P=0xA5, A=X=0, S=0.
   - Stimulus: wrp with X=0xFF, then incp.
   - Required: P=0x00, p_wrap high exactly one cycle.
2. X loads and priority:
   - Stimulus: dbus_in=0x3C, wrx, xin=0001.
   - Required: X=0x3C.
   - Stimulus: xin=0011 with wrx.
   - Required: X holds 0x3C.
   - Stimulus: wrp and incp in the same cycle.
   - Required: P=0x3C (wrp wins).
3. Multi-bit left shift:
   - Stimulus: X=0x81, shift_dir=0, shift_in=1, shift_amt=3, shift_start.
   - Required: busy 3 cycles, X=0x0F, done one pulse.
   - Stimulus: wrx during busy.
   - Required: ignored.
4. Edge amounts:
   - Stimulus: shift_amt=0.
   - Required: done next cycle, busy never set.
   - Stimulus: shift_amt=12, shift_dir=1, shift_in=0.
   - Required: 8 busy cycles, X=0x00.
5. Reset mid-shift:
   - Stimulus: rst asserted on the 2nd busy cycle.
   - Required: busy=0, X=0, no done pulse, next shift_start accepted.
6. Bus conflict:
   - Stimulus: dep=rda=1, sw=0x11, A=0x22.
   - Required: dbus_out=0x11, dbus_oe=1, bus_conflict=1.
   - Stimulus: rdp only.
   - Required: abus_out=P, bus_conflict=0.
